// File: rtl/alu_sequencer.sv
// Byte-stream front end for the ALU: gathers A, B and opcode from a serial
// receiver, latches the ALU result and hands it to a serial transmitter.
module alu_sequencer #(
  parameter int N_BITS         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic [N_BITS-1:0] o_alu_a,
  output logic [N_BITS-1:0] o_alu_b,
  output logic [5:0]        o_alu_op,
  input  logic [N_BITS-1:0] i_alu_result,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  input  logic              i_tx_done,
  output logic [N_BITS-1:0] o_result,
  output logic              o_error,
  output logic              o_timeout,
  output logic              o_overrun
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] aluA_q, aluA_d;
  logic [N_BITS-1:0] aluB_q, aluB_d;
  logic [5:0]        aluOp_q, aluOp_d;
  logic [N_BITS-1:0] txData_q, txData_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic              txStart_q, txStart_d;
  logic              error_q, error_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              opLegal;

  always_comb begin
    case (i_rx_data[5:0])
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b000011, 6'b000010: opLegal = 1'b1;
      default:                                    opLegal = 1'b0;
    endcase
  end

  // The start pulse is decided one cycle ahead (from EXEC onward) so that it
  // is already visible while SEND is active; SEND leaves once it has been seen.
  always_comb begin
    state_d   = state_q;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    aluOp_d   = aluOp_q;
    txData_d  = txData_q;
    result_d  = result_q;
    txStart_d = 1'b0;
    error_d   = 1'b0;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    cnt_d     = '0;
    case (state_q)
      WAIT_A: begin
        if (i_rx_valid) begin
          aluA_d  = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B, WAIT_OP: begin
        if (i_rx_valid) begin
          if (state_q == WAIT_B) begin
            aluB_d  = i_rx_data;
            state_d = WAIT_OP;
          end else if (opLegal) begin
            aluOp_d = i_rx_data[5:0];
            state_d = EXEC;
          end else begin
            error_d = 1'b1;
            state_d = WAIT_A;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXEC: begin
        txData_d  = i_alu_result;
        result_d  = i_alu_result;
        txStart_d = ~i_tx_busy;
        state_d   = SEND;
      end
      SEND: begin
        if (txStart_q) state_d = WAIT_DONE;
        else           txStart_d = ~i_tx_busy;
      end
      WAIT_DONE: begin
        if (i_tx_done) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
    if (i_rx_valid && (state_q == EXEC || state_q == SEND || state_q == WAIT_DONE))
      overrun_d = 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q   <= WAIT_A;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluOp_q   <= '0;
      txData_q  <= '0;
      result_q  <= '0;
      txStart_q <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      aluOp_q   <= aluOp_d;
      txData_q  <= txData_d;
      result_q  <= result_d;
      txStart_q <= txStart_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_alu_a    = aluA_q;
  assign o_alu_b    = aluB_q;
  assign o_alu_op   = aluOp_q;
  assign o_tx_data  = txData_q;
  assign o_result   = result_q;
  assign o_tx_start = txStart_q;
  assign o_error    = error_q;
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Byte-stream controller that drives the ALU datapath in place of the three load buttons. It sits between a serial receiver (byte + strobe) and a serial transmitter (start/busy/done). It collects operand A, operand B and the opcode as three consecutive received bytes, then drives the ALU. It latches the combinational result and hands it to the transmitter, with opcode validation and an inter-byte timeout.

## Interface
Parameters:
- N_BITS, 8, ALU operand/result width and received byte width
- TIMEOUT_CYCLES, 1000000, maximum clock cycles allowed between bytes of one frame (≥2)

Ports:
- i_clock  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_rx_data  in  N_BITS  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid this cycle
- o_alu_a  out  N_BITS  operand A to ALU
- o_alu_b  out  N_BITS  operand B to ALU
- o_alu_op  out  6  opcode to ALU
- i_alu_result  in  N_BITS  combinational ALU result
- o_tx_data  out  N_BITS  byte to transmit, held stable from o_tx_start until i_tx_done
- o_tx_start  out  1  one-cycle transmit request
- i_tx_busy  in  1  transmitter busy
- i_tx_done  in  1  one-cycle strobe, transmission finished
- o_result  out  N_BITS  last latched result (LED mirror)
- o_error  out  1  one-cycle pulse, invalid opcode
- o_timeout  out  1  one-cycle pulse, frame abandoned
- o_overrun  out  1  one-cycle pulse, byte dropped

## Operation
- Reset (i_reset_n=0 at a clock edge): state WAIT_A; all outputs, registers and the timeout counter are 0. Reset overrides everything, including mid-frame and mid-transmission.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_DONE.
- WAIT_A: on i_rx_valid, o_alu_a <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_valid, o_alu_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_valid, check i_rx_data[5:0] against the legal set 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL. Upper received bits are ignored.
  - Legal: o_alu_op <= i_rx_data[5:0], go to EXEC.
  - Illegal: o_error pulses, o_alu_op is unchanged, go to WAIT_A.
- EXEC: o_tx_data <= i_alu_result and o_result <= i_alu_result, go to SEND.
- SEND: when i_tx_busy=0, pulse o_tx_start and go to WAIT_DONE; otherwise wait in SEND.
- WAIT_DONE: on i_tx_done, go to WAIT_A.
- Timeout counter:
  - Counts only in WAIT_B and WAIT_OP; cleared on every accepted byte and in all other states.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_valid that cycle: o_timeout pulses, counter clears, go to WAIT_A. o_alu_a and o_alu_b keep their values.
  - If i_rx_valid coincides with expiry, the byte is accepted and no timeout occurs.
- Overrun: i_rx_valid in EXEC, SEND or WAIT_DONE pulses o_overrun on the next cycle. The byte is discarded and the state is unaffected.
- Arithmetic is performed entirely by the ALU; this block does no width extension and adds no carry bit.

## Timing
- Byte capture: registers update on the edge where i_rx_valid=1; the next state is active the following cycle.
- Opcode byte accepted at edge k: EXEC during cycle k+1, result latched at edge k+1. o_tx_start is asserted in cycle k+2 at the earliest, when i_tx_busy=0.
- o_tx_start, o_error, o_timeout and o_overrun are registered and high for exactly one cycle.
- o_tx_data and o_result stay constant from the EXEC latch until the next EXEC.
- o_alu_a, o_alu_b and o_alu_op change only on accepted bytes or reset.
- i_tx_done received outside WAIT_DONE is ignored.

## Test plan
- Bytes 0x01, 0x01, 0x20, one per 10 cycles, transmitter idle -> o_alu_op=100000; o_tx_start pulses 2 cycles after the third byte; o_tx_data=o_result=0x02.
- Bytes 0x23, 0x14, 0x22 (SUB) -> o_tx_data=0x0F. Then 0x64, 0x05, 0x03 (SRA) -> o_tx_data=0x03 (0x64>>>5). Each transmission completes on i_tx_done and the block returns to WAIT_A.
- Bytes 0x05, 0x03, 0x3F -> o_error one pulse; no o_tx_start; o_alu_op keeps its previous value; the next frame 0x02, 0x02, 0x25 (OR) works normally -> 0x02.
- TIMEOUT_CYCLES=16, send only 0x07 then idle -> o_timeout pulses exactly 16 cycles after the byte; the next byte 0x09 is loaded as A. Repeat with a byte arriving on the expiry cycle -> no timeout, byte loaded as B.
- Hold i_tx_busy=1 for 20 cycles after EXEC and inject i_rx_valid during that window -> o_tx_start only after busy falls; o_overrun pulses; frame data unchanged.
- Assert i_reset_n=0 for one edge while in WAIT_OP and again in WAIT_DONE -> all outputs 0, state WAIT_A; a following full frame executes correctly.
